gate_pattern_sequencer: RTL and testbench
=========================================

Name: gate_pattern_sequencer

Overview:
- Parametrised stimulus-and-response block for basic gate modelling.
- Walks a WIDTH-bit input vector through all 2^WIDTH patterns in binary or Gray order.
- Holds each pattern for HOLD clock cycles and presents aligned AND/OR reductions of the vector.
- Sits alongside gate models as a self-timed exerciser; start/done handshake to a controller or bench.

Parameters:
- WIDTH, 2, vector width; legal range 1..16.
- HOLD, 5, clock cycles each pattern is held; legal range 1..65535.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request a sweep; sampled only in IDLE.
- mode_gray  input  1  0 = binary order, 1 = Gray order; latched when start is accepted.
- abort  input  1  terminate a sweep in progress.
- busy  output  1  high in RUN.
- valid  output  1  vec_out/and_out/or_out carry a live pattern.
- vec_out  output  WIDTH  current pattern.
- and_out  output  1  &vec_out, qualified by valid.
- or_out  output  1  |vec_out, qualified by valid.
- pat_idx  output  WIDTH  index of current pattern (binary, 0..2^WIDTH-1).
- done  output  1  one-cycle pulse at sweep completion.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, any state) forces:
  - state = IDLE.
  - busy, valid, done, and_out, or_out = 0.
  - vec_out, pat_idx = 0.
  - hold counter = 0; latched mode = 0.
- IDLE:
  - start=1 at an edge: enter RUN at that edge, pat_idx=0, hold counter=0, latch mode_gray.
  - valid=1 and vec_out=pattern(0) from that edge, i.e. latency 1 cycle after the start sample.
  - abort is ignored in IDLE.
- RUN:
  - The hold counter counts 0..HOLD-1.
  - On the edge where counter = HOLD-1 and pat_idx < 2^WIDTH-1: pat_idx increments and the counter clears.
  - On the edge where counter = HOLD-1 and pat_idx = 2^WIDTH-1: go to DONE.
  - Each pattern is therefore visible for exactly HOLD cycles.
  - Total RUN length is HOLD*2^WIDTH cycles.
- Pattern encoding:
  - Binary: vec_out = pat_idx.
  - Gray: vec_out = pat_idx ^ (pat_idx >> 1).
  - vec_out is registered and updated on the same edge as pat_idx.
- Reductions:
  - and_out and or_out are derived from the registered vec_out and are cycle-aligned with it.
  - Both are forced to 0 when valid=0.
- DONE:
  - Lasts one cycle: done=1, busy=0, valid=0, vec_out=0, pat_idx=0.
  - Next edge returns to IDLE.
  - A start present during DONE is ignored; it must be sampled again in IDLE.
- abort in RUN:
  - Next edge goes to IDLE with busy=0, valid=0, vec_out=0, pat_idx=0.
  - No done pulse.
  - abort has priority over pattern advance and completion on the same edge.
- start while RUN or DONE: ignored.
- mode_gray changes during RUN: no effect; the latched mode is used.
- HOLD=1: a new pattern on every cycle.
- WIDTH=1: two patterns, 0 then 1; Gray and binary orders are identical.
- Counter widths:
  - Hold counter is sized to hold HOLD-1.
  - pat_idx is WIDTH bits; completion is detected by comparison, never by wrap-around.

Optional Feature:
- Macro: GATE_SEQ_XOR_EN.
- Defined: adds output xor_out (1 bit) = ^vec_out.
  - Same alignment and valid qualification as and_out.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- WIDTH=2, HOLD=5, mode_gray=0, start pulse at edge 0:
  - vec_out = 00, 01, 10, 11, each for 5 cycles, from edge 0.
  - and_out=1 only during 11 (edges 15-19).
  - or_out=0 only during 00 (edges 0-4).
  - done=1 in the cycle after edge 20; busy low after edge 20.
- Same configuration, mode_gray=1:
  - vec_out = 00, 01, 11, 10.
  - pat_idx = 0, 1, 2, 3.
  - and_out=1 during pat_idx 2.
- Abort, WIDTH=2, HOLD=5:
  - abort asserted at edge 7 (pattern 01) -> IDLE at that edge, valid=0, vec_out=0, no done.
  - A new start afterwards runs a full sweep.
- Reset mid-run:
  - rst asserted asynchronously between edges during pattern 10 -> all outputs 0 immediately, without waiting for an edge.
  - After release, the block stays IDLE until start.
- Boundary, WIDTH=3, HOLD=1:
  - 8 consecutive patterns, one per cycle, done after 8 cycles.
  - start held high through DONE does not restart until the block is in IDLE.
  - mode_gray toggled mid-run has no effect.
- GATE_SEQ_XOR_EN defined, WIDTH=2, binary order:
  - xor_out = 0, 1, 1, 0 across the sweep.
  - xor_out = 0 when valid=0.

Source files
------------

// File: rtl/gate_pattern_sequencer.sv
// Sweeps a WIDTH-bit vector through all patterns in binary or Gray order.
// Optional xor_out reduction is enabled by defining GATE_SEQ_XOR_EN.
module gate_pattern_sequencer #(
  parameter int WIDTH = 2,
  parameter int HOLD  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode_gray,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_vec_out,
  output logic             o_and_out,
  output logic             o_or_out,
  output logic [WIDTH-1:0] o_pat_idx,
  output logic             o_done
`ifdef GATE_SEQ_XOR_EN
  ,
  output logic             o_xor_out
`endif
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]    HMAX = CW'(HOLD - 1);
  localparam logic [WIDTH-1:0] IMAX = {WIDTH{1'b1}};

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_idx;
  logic [WIDTH-1:0] r_vec;
  logic             r_mode;

  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_enc;

  assign w_nxt = r_idx + WIDTH'(1);
  assign w_enc = r_mode ? (w_nxt ^ (w_nxt >> 1)) : w_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_vec   <= '0;
      r_mode  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_vec   <= '0;
            r_mode  <= i_mode_gray;
          end
        end
        S_RUN: begin
          // abort wins over advance and completion
          if (i_abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_vec   <= '0;
          end else if (r_cnt == HMAX) begin
            r_cnt <= '0;
            if (r_idx == IMAX) begin
              r_state <= S_DONE;
              r_idx   <= '0;
              r_vec   <= '0;
            end else begin
              r_idx <= w_nxt;
              r_vec <= w_enc;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state == S_RUN);
  assign o_valid   = (r_state == S_RUN);
  assign o_done    = (r_state == S_DONE);
  assign o_vec_out = r_vec;
  assign o_pat_idx = r_idx;
  assign o_and_out = o_valid & (&r_vec);
  assign o_or_out  = o_valid & (|r_vec);
`ifdef GATE_SEQ_XOR_EN
  assign o_xor_out = o_valid & (^r_vec);
`endif

endmodule

// File: tb/tb_gate_pattern_sequencer.sv
// Directed bench: WIDTH=2/HOLD=5 and WIDTH=3/HOLD=1 instances.
// Checks sweeps, abort, async reset, start-through-DONE, mode latching.
module tb_gate_pattern_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic a_start = 0, a_mode = 0, a_abort = 0;
  logic a_busy, a_valid, a_and, a_or, a_done;
  logic [1:0] a_vec, a_idx;

  logic b_start = 0, b_mode = 0, b_abort = 0;
  logic b_busy, b_valid, b_and, b_or, b_done;
  logic [2:0] b_vec, b_idx;

`ifdef GATE_SEQ_XOR_EN
  logic a_xor, b_xor;
`endif

  gate_pattern_sequencer #(.WIDTH(2), .HOLD(5)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start),
    .i_mode_gray(a_mode), .i_abort(a_abort),
    .o_busy(a_busy), .o_valid(a_valid), .o_vec_out(a_vec),
    .o_and_out(a_and), .o_or_out(a_or), .o_pat_idx(a_idx),
    .o_done(a_done)
`ifdef GATE_SEQ_XOR_EN
    , .o_xor_out(a_xor)
`endif
  );

  gate_pattern_sequencer #(.WIDTH(3), .HOLD(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start),
    .i_mode_gray(b_mode), .i_abort(b_abort),
    .o_busy(b_busy), .o_valid(b_valid), .o_vec_out(b_vec),
    .o_and_out(b_and), .o_or_out(b_or), .o_pat_idx(b_idx),
    .o_done(b_done)
`ifdef GATE_SEQ_XOR_EN
    , .o_xor_out(b_xor)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] enc(input int k, input bit g);
    logic [3:0] b;
    b = k[3:0];
    return g ? (b ^ (b >> 1)) : b;
  endfunction

  task automatic a_idle_chk(input string tag);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_valid"}, a_valid, 0);
    chk({tag, "_vec"}, a_vec, 0);
    chk({tag, "_idx"}, a_idx, 0);
    chk({tag, "_and"}, a_and, 0);
    chk({tag, "_or"}, a_or, 0);
    chk({tag, "_done"}, a_done, 0);
  endtask

  // Start pulse sampled at "edge 0"; returns half a cycle after it.
  task automatic a_go(input bit g);
    @(negedge clk);
    a_start = 1; a_mode = g;
    @(negedge clk);
    a_start = 0; a_mode = ~g;
  endtask

  task automatic a_sweep(input bit g);
    logic [3:0] p;
    a_go(g);
    for (int k = 0; k < 20; k++) begin
      p = enc(k / 5, g);
      chk("a_vec", a_vec, p);
      chk("a_idx", a_idx, k / 5);
      chk("a_and", a_and, p == 3);
      chk("a_or", a_or, p != 0);
      chk("a_valid", a_valid, 1);
      chk("a_busy", a_busy, 1);
      chk("a_done", a_done, 0);
`ifdef GATE_SEQ_XOR_EN
      chk("a_xor", a_xor, ^p[1:0]);
`endif
      @(negedge clk);
    end
    chk("a_done_pulse", a_done, 1);
    chk("a_done_busy", a_busy, 0);
    chk("a_done_valid", a_valid, 0);
    chk("a_done_vec", a_vec, 0);
    chk("a_done_idx", a_idx, 0);
`ifdef GATE_SEQ_XOR_EN
    chk("a_done_xor", a_xor, 0);
`endif
    @(negedge clk);
    a_idle_chk("a_post");
  endtask

  initial begin
    #3;
    a_idle_chk("rst");
    chk("rst_b_valid", b_valid, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    a_idle_chk("idle");

    // abort ignored in IDLE
    a_abort = 1;
    @(negedge clk);
    a_abort = 0;
    a_idle_chk("idle_abort");

    a_sweep(0);
    a_sweep(1);

    // abort sampled at edge 7, during pattern 01
    a_go(0);
    repeat (6) @(negedge clk);
    chk("ab_pre_vec", a_vec, 1);
    a_abort = 1;
    @(negedge clk);
    a_abort = 0;
    a_idle_chk("ab");
    repeat (20) begin
      @(negedge clk);
      chk("ab_nodone", a_done, 0);
    end
    a_sweep(0);

    // async reset during pattern 10
    a_go(0);
    repeat (11) @(negedge clk);
    chk("rr_pre_vec", a_vec, 2);
    #2 rst = 1;
    #1;
    a_idle_chk("rr");
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    a_idle_chk("rr_idle");

    // WIDTH=3 HOLD=1, start held high throughout
    @(negedge clk);
    b_start = 1; b_mode = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) b_mode = 1;
      chk("b_vec", b_vec, k);
      chk("b_idx", b_idx, k);
      chk("b_and", b_and, k == 7);
      chk("b_valid", b_valid, 1);
    end
    @(negedge clk);
    chk("b_done", b_done, 1);
    chk("b_done_valid", b_valid, 0);
    @(negedge clk);
    chk("b_idle_done", b_done, 0);
    chk("b_idle_busy", b_busy, 0);
    chk("b_idle_valid", b_valid, 0);
    @(negedge clk);
    b_start = 0;
    for (int k = 0; k < 8; k++) begin
      chk("bg_vec", b_vec, enc(k, 1));
      chk("bg_idx", b_idx, k);
      chk("bg_busy", b_busy, 1);
      @(negedge clk);
    end
    chk("bg_done", b_done, 1);
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("bg_end_busy", b_busy, 0);
    chk("bg_end_done", b_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
